alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares a single 4-bit `alu` instance between two independent requesters using valid/ready handshakes on the request and response sides. Each accepted operation (A, B, opcode) is registered, executed in one cycle on the shared ALU, and its result and flags are returned only to the requester that issued it. The block sits between the ALU datapath and the two command sources, and is the only driver of the ALU inputs.

## Interface
- `PRIO_MODE`, 0: arbitration policy. 0 = round-robin, 1 = fixed priority, with requester 0 always winning.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `req_valid_0`, `req_valid_1`  input  1 each  request valid per requester.
- `req_ready_0`, `req_ready_1`  output  1 each  request accepted this cycle.
- `req_a_0`, `req_a_1`  input  4 each  operand A.
- `req_b_0`, `req_b_1`  input  4 each  operand B.
- `req_op_0`, `req_op_1`  input  4 each  ALU opcode: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 NOT A, 1111 PASS A; all others invalid.
- `rsp_valid_0`, `rsp_valid_1`  output  1 each  response valid.
- `rsp_ready_0`, `rsp_ready_1`  input  1 each  response consumed.
- `rsp_result`  output  4  registered ALU result, shared by both response channels.
- `rsp_carry`, `rsp_zero`  output  1 each  registered ALU carry and zero flags.
- `busy`  output  1  high whenever the state is not IDLE.
- `done_count`  output  8  count of completed responses; wraps from 255 to 0.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - Arbitrate among the asserted `req_valid_x`.
  - `req_ready_x` is combinational: high only for the winner, only in IDLE.
  - On the edge where valid&ready: latch A, B, opcode and owner ID, then go to EXEC.
  - With no valid request, stay in IDLE.
- **EXEC**
  - ALU inputs come from the latched registers.
  - At the edge, latch the ALU result, carry and zero into `rsp_*` registers, then go to RESP.
- **RESP**
  - `rsp_valid_owner` is high and the other `rsp_valid` is low.
  - `rsp_result` and flags hold stable until `rsp_ready_owner` is high at an edge.
  - At that edge: increment `done_count` and go to IDLE.
  - `rsp_ready` of the non-owner is ignored.
- **Round-robin (`PRIO_MODE` = 0)**
  - `last_grant` resets to 1, so requester 0 wins the first simultaneous request.
  - On simultaneous requests, the requester other than `last_grant` wins.
  - `last_grant` updates at every acceptance.
  - A lone requester always wins.
- **Fixed priority (`PRIO_MODE` = 1)**: requester 0 wins whenever `req_valid_0` is high.
- ALU outputs are forwarded unmodified. An invalid opcode is executed and returns whatever the ALU produces (result 0000); it is not flagged as an error.
- Requester rules:
  - A requester holds valid and payload stable until accepted.
  - Dropping valid before acceptance is a protocol violation; behaviour is undefined.
- While a transaction is in EXEC or RESP, both `req_ready` outputs are 0 and no new request is accepted.
- No idle bubble is inserted, so a new request can be accepted in the cycle after the response handshake.

## Timing
- Reset (asynchronous, takes effect immediately):
  - State → IDLE.
  - `req_ready_*` = 0, `rsp_valid_*` = 0, `rsp_result` = 0000, `rsp_carry` = 0, `rsp_zero` = 0, `busy` = 0, `done_count` = 0, `last_grant` = 1.
- Reset asserted mid-transaction: the in-flight operation is discarded, no response is issued, and `done_count` is unchanged from its reset value of 0.
- Latency: if the request is accepted at edge t, `rsp_valid` is high from edge t+1.
- Minimum issue interval: 3 cycles per operation (accept, execute, respond with immediate `rsp_ready`).
- `rsp_ready` held low stalls the block indefinitely in RESP with its outputs stable.
- `req_ready` depends only on the state, `req_valid_*` and `last_grant`; it never depends on `rsp_ready`.
- `done_count` wraps 255 → 0 without any flag.

## Test plan
- **Single ADD, requester 0:** A=3, B=2, op=0000.
  - `req_ready_0` is high in the same cycle.
  - `rsp_valid_0` is high one edge after acceptance, with result 0101, carry 0, zero 0.
  - `rsp_valid_1` stays 0.
- **Simultaneous requests, round-robin, out of reset:**
  - Requester 0: SUB 5−5. Requester 1: AND 1010&1100.
  - Requester 0 is served first: result 0000, zero 1.
  - Requester 1 is served next: result 1000, zero 0.
  - With both valids held continuously, grants alternate 0, 1, 0, 1.
- **Fixed priority:** with `PRIO_MODE` = 1 and both valids held continuously, requester 0 wins every grant and `req_ready_1` never asserts.
- **Backpressure:** OR 1010|1100 with `rsp_ready` held low for 5 cycles.
  - `rsp_valid` stays high and result stays 1110 throughout.
  - `busy` = 1 and `req_ready_*` = 0 throughout.
  - After `rsp_ready` rises: `done_count` increments by 1 and the block returns to IDLE.
- **Overflow and invalid opcode:**
  - ADD 15+1 → result 0000, carry 1, zero 1.
  - op=1000 with A=3, B=3 → result 0000.
  - After 256 completed operations, `done_count` reads 0.
- **Reset mid-operation:** assert `rst_n` low while in EXEC.
  - All outputs go to their reset values immediately.
  - No `rsp_valid` pulse appears after reset is released.

Source files
------------

// File: rtl/alu_arbiter.sv
// Shares one 4-bit ALU between two valid/ready requesters.
// Each accepted operation runs for one cycle and its result goes back only to the requester that issued it.

module alu (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] op,
  output logic [3:0] result,
  output logic       carry,
  output logic       zero
);

  logic [4:0] wide;

  // For SUB, carry reports a borrow (set when a < b).
  always_comb begin
    wide   = 5'd0;
    result = 4'd0;
    carry  = 1'b0;
    case (op)
      4'b0000: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[3:0];
        carry  = wide[4];
      end
      4'b0001: begin
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[3:0];
        carry  = wide[4];
      end
      4'b0010: result = a & b;
      4'b0011: result = a | b;
      4'b0100: result = ~a;
      4'b1111: result = a;
      default: result = 4'd0;
    endcase
  end

  assign zero = (result == 4'd0);

endmodule

module alu_arbiter #(
  parameter int PRIO_MODE = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid_0,
  input  logic       req_valid_1,
  output logic       req_ready_0,
  output logic       req_ready_1,
  input  logic [3:0] req_a_0,
  input  logic [3:0] req_a_1,
  input  logic [3:0] req_b_0,
  input  logic [3:0] req_b_1,
  input  logic [3:0] req_op_0,
  input  logic [3:0] req_op_1,
  output logic       rsp_valid_0,
  output logic       rsp_valid_1,
  input  logic       rsp_ready_0,
  input  logic       rsp_ready_1,
  output logic [3:0] rsp_result,
  output logic       rsp_carry,
  output logic       rsp_zero,
  output logic       busy,
  output logic [7:0] done_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state;
  state_t     next_state;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic [3:0] op_code;
  logic       owner;
  logic       last_grant;
  logic       grant_0;
  logic       grant_1;
  logic       accept;
  logic       owner_ready;
  logic [3:0] alu_result;
  logic       alu_carry;
  logic       alu_zero;

  alu u_alu (
    .a      (op_a),
    .b      (op_b),
    .op     (op_code),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  // last_grant == 1 means requester 0 wins the next tie.
  always_comb begin
    grant_0 = 1'b0;
    grant_1 = 1'b0;
    if (state == IDLE) begin
      if (PRIO_MODE != 0) begin
        grant_0 = req_valid_0;
        grant_1 = req_valid_1 && !req_valid_0;
      end else if (req_valid_0 && req_valid_1) begin
        grant_0 = last_grant;
        grant_1 = !last_grant;
      end else begin
        grant_0 = req_valid_0;
        grant_1 = req_valid_1;
      end
    end
  end

  assign accept      = grant_0 || grant_1;
  assign owner_ready = owner ? rsp_ready_1 : rsp_ready_0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = EXEC;
      EXEC:    next_state = RESP;
      RESP:    if (owner_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready_0 = grant_0;
    req_ready_1 = grant_1;
    rsp_valid_0 = (state == RESP) && !owner;
    rsp_valid_1 = (state == RESP) && owner;
    busy        = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a       <= 4'd0;
      op_b       <= 4'd0;
      op_code    <= 4'd0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      rsp_result <= 4'd0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      done_count <= 8'd0;
    end else begin
      if (accept) begin
        op_a       <= grant_1 ? req_a_1 : req_a_0;
        op_b       <= grant_1 ? req_b_1 : req_b_0;
        op_code    <= grant_1 ? req_op_1 : req_op_0;
        owner      <= grant_1;
        last_grant <= grant_1;
      end
      if (state == EXEC) begin
        rsp_result <= alu_result;
        rsp_carry  <= alu_carry;
        rsp_zero   <= alu_zero;
      end
      if (state == RESP && owner_ready) begin
        done_count <= done_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: one round-robin instance and one fixed-priority instance.
// Stimulus pushes hand-computed responses; per-instance monitors pop them on each response handshake.

module tb_alu_arbiter;

  typedef struct {
    logic       owner;
    logic [3:0] result;
    logic       carry;
    logic       zero;
    logic       check_carry;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       rr_req_valid_0, rr_req_valid_1, rr_req_ready_0, rr_req_ready_1;
  logic [3:0] rr_req_a_0, rr_req_a_1, rr_req_b_0, rr_req_b_1, rr_req_op_0, rr_req_op_1;
  logic       rr_rsp_valid_0, rr_rsp_valid_1, rr_rsp_ready_0, rr_rsp_ready_1;
  logic [3:0] rr_rsp_result;
  logic       rr_rsp_carry, rr_rsp_zero, rr_busy;
  logic [7:0] rr_done_count;

  logic       fp_req_valid_0, fp_req_valid_1, fp_req_ready_0, fp_req_ready_1;
  logic [3:0] fp_req_a_0, fp_req_a_1, fp_req_b_0, fp_req_b_1, fp_req_op_0, fp_req_op_1;
  logic       fp_rsp_valid_0, fp_rsp_valid_1, fp_rsp_ready_0, fp_rsp_ready_1;
  logic [3:0] fp_rsp_result;
  logic       fp_rsp_carry, fp_rsp_zero, fp_busy;
  logic [7:0] fp_done_count;

  exp_t rr_q[$];
  exp_t fp_q[$];
  int   n_compared = 0;
  int   n_mismatched = 0;

  alu_arbiter #(.PRIO_MODE(0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0(rr_req_valid_0), .req_valid_1(rr_req_valid_1),
    .req_ready_0(rr_req_ready_0), .req_ready_1(rr_req_ready_1),
    .req_a_0(rr_req_a_0), .req_a_1(rr_req_a_1),
    .req_b_0(rr_req_b_0), .req_b_1(rr_req_b_1),
    .req_op_0(rr_req_op_0), .req_op_1(rr_req_op_1),
    .rsp_valid_0(rr_rsp_valid_0), .rsp_valid_1(rr_rsp_valid_1),
    .rsp_ready_0(rr_rsp_ready_0), .rsp_ready_1(rr_rsp_ready_1),
    .rsp_result(rr_rsp_result), .rsp_carry(rr_rsp_carry), .rsp_zero(rr_rsp_zero),
    .busy(rr_busy), .done_count(rr_done_count)
  );

  alu_arbiter #(.PRIO_MODE(1)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0(fp_req_valid_0), .req_valid_1(fp_req_valid_1),
    .req_ready_0(fp_req_ready_0), .req_ready_1(fp_req_ready_1),
    .req_a_0(fp_req_a_0), .req_a_1(fp_req_a_1),
    .req_b_0(fp_req_b_0), .req_b_1(fp_req_b_1),
    .req_op_0(fp_req_op_0), .req_op_1(fp_req_op_1),
    .rsp_valid_0(fp_rsp_valid_0), .rsp_valid_1(fp_rsp_valid_1),
    .rsp_ready_0(fp_rsp_ready_0), .rsp_ready_1(fp_rsp_ready_1),
    .rsp_result(fp_rsp_result), .rsp_carry(fp_rsp_carry), .rsp_zero(fp_rsp_zero),
    .busy(fp_busy), .done_count(fp_done_count)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_compared++;
    n_mismatched++;
    $display("[TB] FAIL %s: actual=timeout/unexpected required=event", name);
  endtask

  task automatic compare_rsp(input string tag, input exp_t e, input logic owner,
                             input logic [3:0] res, input logic c, input logic z);
    check({tag, "_owner"}, {7'd0, owner}, {7'd0, e.owner});
    check({tag, "_result"}, {4'd0, res}, {4'd0, e.result});
    check({tag, "_zero"}, {7'd0, z}, {7'd0, e.zero});
    if (e.check_carry) check({tag, "_carry"}, {7'd0, c}, {7'd0, e.carry});
  endtask

  // Monitors: compare on the negedge before each response handshake edge.
  always @(negedge clk) begin
    if (rst_n && (rr_rsp_valid_0 || rr_rsp_valid_1)) begin
      check("rr_rsp_valid_onehot", {7'd0, rr_rsp_valid_0 & rr_rsp_valid_1}, 8'd0);
      if ((rr_rsp_valid_0 && rr_rsp_ready_0) || (rr_rsp_valid_1 && rr_rsp_ready_1)) begin
        if (rr_q.size() == 0) fail_now("rr_unexpected_rsp");
        else compare_rsp("rr_rsp", rr_q.pop_front(), rr_rsp_valid_1,
                         rr_rsp_result, rr_rsp_carry, rr_rsp_zero);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && (fp_rsp_valid_0 || fp_rsp_valid_1)) begin
      if ((fp_rsp_valid_0 && fp_rsp_ready_0) || (fp_rsp_valid_1 && fp_rsp_ready_1)) begin
        if (fp_q.size() == 0) fail_now("fp_unexpected_rsp");
        else compare_rsp("fp_rsp", fp_q.pop_front(), fp_rsp_valid_1,
                         fp_rsp_result, fp_rsp_carry, fp_rsp_zero);
      end
    end
  end

  function automatic exp_t mk(input logic owner, input logic [3:0] r, input logic c,
                              input logic z, input logic cc);
    exp_t e;
    e.owner = owner; e.result = r; e.carry = c; e.zero = z; e.check_carry = cc;
    return e;
  endfunction

  task automatic do_reset(input logic check_values);
    rst_n = 1'b0;
    #2;
    if (check_values) begin
      check("reset_req_ready", {6'd0, rr_req_ready_1, rr_req_ready_0}, 8'd0);
      check("reset_rsp_valid", {6'd0, rr_rsp_valid_1, rr_rsp_valid_0}, 8'd0);
      check("reset_rsp_flags", {2'd0, rr_rsp_result, rr_rsp_carry, rr_rsp_zero}, 8'd0);
      check("reset_busy", {7'd0, rr_busy}, 8'd0);
      check("reset_done_count", rr_done_count, 8'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after acceptance with valid dropped.
  task automatic applyStimulus(input logic id, input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] op, input exp_t e);
    logic got;
    got = 1'b0;
    rr_q.push_back(e);
    if (id) begin
      rr_req_a_1 = a; rr_req_b_1 = b; rr_req_op_1 = op; rr_req_valid_1 = 1'b1;
    end else begin
      rr_req_a_0 = a; rr_req_b_0 = b; rr_req_op_0 = op; rr_req_valid_0 = 1'b1;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (id ? rr_req_ready_1 : rr_req_ready_0) got = 1'b1;
    end
    if (!got) begin
      fail_now("rr_accept_timeout");
      void'(rr_q.pop_back());
    end else begin
      @(posedge clk);
    end
    #1;
    rr_req_valid_0 = 1'b0;
    rr_req_valid_1 = 1'b0;
  endtask

  task automatic wait_rr_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (!rr_busy && rr_q.size() == 0) ok = 1'b1;
    end
    if (!ok) fail_now("rr_idle_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fp_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (!fp_busy && fp_q.size() == 0) ok = 1'b1;
    end
    if (!ok) fail_now("fp_idle_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    check(name, act, exp);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=still running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic got;
    logic [3:0] av;
    rr_req_valid_0 = 0; rr_req_valid_1 = 0; rr_rsp_ready_0 = 1; rr_rsp_ready_1 = 1;
    rr_req_a_0 = 0; rr_req_a_1 = 0; rr_req_b_0 = 0; rr_req_b_1 = 0; rr_req_op_0 = 0; rr_req_op_1 = 0;
    fp_req_valid_0 = 0; fp_req_valid_1 = 0; fp_rsp_ready_0 = 1; fp_rsp_ready_1 = 1;
    fp_req_a_0 = 0; fp_req_a_1 = 0; fp_req_b_0 = 0; fp_req_b_1 = 0; fp_req_op_0 = 0; fp_req_op_1 = 0;

    do_reset(1'b1);

    // Single ADD 3+2 from requester 0.
    rr_q.push_back(mk(1'b0, 4'b0101, 1'b0, 1'b0, 1'b1));
    rr_req_a_0 = 4'd3; rr_req_b_0 = 4'd2; rr_req_op_0 = 4'b0000; rr_req_valid_0 = 1'b1;
    @(negedge clk);
    checkOutput("add_req_ready_0", {7'd0, rr_req_ready_0}, 8'd1);
    checkOutput("add_req_ready_1", {7'd0, rr_req_ready_1}, 8'd0);
    @(posedge clk); #1;
    rr_req_valid_0 = 1'b0;
    checkOutput("add_busy_exec", {7'd0, rr_busy}, 8'd1);
    @(posedge clk); #1;
    checkOutput("add_rsp_valid_0", {7'd0, rr_rsp_valid_0}, 8'd1);
    checkOutput("add_rsp_valid_1", {7'd0, rr_rsp_valid_1}, 8'd0);
    wait_rr_idle();

    // Simultaneous requests from reset: grants alternate 0,1,0,1.
    do_reset(1'b0);
    for (int g = 0; g < 4; g++) begin
      if (g % 2 == 0) rr_q.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0));
      else            rr_q.push_back(mk(1'b1, 4'b1000, 1'b0, 1'b0, 1'b1));
    end
    rr_req_a_0 = 4'd5; rr_req_b_0 = 4'd5; rr_req_op_0 = 4'b0001; rr_req_valid_0 = 1'b1;
    rr_req_a_1 = 4'b1010; rr_req_b_1 = 4'b1100; rr_req_op_1 = 4'b0010; rr_req_valid_1 = 1'b1;
    for (int g = 0; g < 4; g++) begin
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        if (rr_req_ready_0 || rr_req_ready_1) begin
          got = 1'b1;
          checkOutput("rr_grant_onehot", {7'd0, rr_req_ready_0 & rr_req_ready_1}, 8'd0);
          checkOutput($sformatf("rr_grant_%0d", g), {7'd0, rr_req_ready_1}, (g % 2 == 1) ? 8'd1 : 8'd0);
        end
      end
      if (!got) fail_now("rr_grant_timeout");
      @(posedge clk);
    end
    #1;
    rr_req_valid_0 = 1'b0;
    rr_req_valid_1 = 1'b0;
    wait_rr_idle();
    checkOutput("rr_done_after_4", rr_done_count, 8'd4);

    // Backpressure: OR 1010|1100 held in RESP for 5 cycles while requester 1 waits.
    rr_rsp_ready_0 = 1'b0;
    applyStimulus(1'b0, 4'b1010, 4'b1100, 4'b0011, mk(1'b0, 4'b1110, 1'b0, 1'b0, 1'b1));
    rr_q.push_back(mk(1'b1, 4'b0110, 1'b0, 1'b0, 1'b1));
    rr_req_a_1 = 4'b0110; rr_req_b_1 = 4'd0; rr_req_op_1 = 4'b1111; rr_req_valid_1 = 1'b1;
    @(negedge clk);
    checkOutput("bp_exec_req_ready_1", {7'd0, rr_req_ready_1}, 8'd0);
    @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput($sformatf("bp_rsp_valid_%0d", c), {7'd0, rr_rsp_valid_0}, 8'd1);
      checkOutput($sformatf("bp_result_%0d", c), {4'd0, rr_rsp_result}, 8'b0000_1110);
      checkOutput($sformatf("bp_busy_%0d", c), {7'd0, rr_busy}, 8'd1);
      checkOutput($sformatf("bp_req_ready_%0d", c), {6'd0, rr_req_ready_1, rr_req_ready_0}, 8'd0);
    end
    @(posedge clk); #1;
    rr_rsp_ready_0 = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_done_count", rr_done_count, 8'd5);
    checkOutput("bp_busy_idle", {7'd0, rr_busy}, 8'd0);
    checkOutput("bp_no_bubble_ready_1", {7'd0, rr_req_ready_1}, 8'd1);
    @(posedge clk); #1;
    rr_req_valid_1 = 1'b0;
    wait_rr_idle();
    checkOutput("bp_done_after_pass", rr_done_count, 8'd6);

    // Overflow and invalid opcode.
    applyStimulus(1'b0, 4'd15, 4'd1, 4'b0000, mk(1'b0, 4'b0000, 1'b1, 1'b1, 1'b1));
    applyStimulus(1'b1, 4'd3, 4'd3, 4'b1000, mk(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0));
    wait_rr_idle();
    checkOutput("ovf_done_count", rr_done_count, 8'd8);

    // done_count wrap after 256 completions from reset.
    do_reset(1'b0);
    for (int i = 0; i < 256; i++) begin
      av = 4'(i);
      applyStimulus(1'(i % 2), av, 4'd0, 4'b1111, mk(1'(i % 2), av, 1'b0, (av == 4'd0), 1'b1));
      if (i == 254) begin
        wait_rr_idle();
        checkOutput("wrap_done_255", rr_done_count, 8'd255);
      end
    end
    wait_rr_idle();
    checkOutput("wrap_done_0", rr_done_count, 8'd0);

    // Reset while in EXEC: operation discarded, no response afterwards.
    applyStimulus(1'b0, 4'd7, 4'd1, 4'b0000, mk(1'b0, 4'b1000, 1'b0, 1'b0, 1'b1));
    wait_rr_idle();
    checkOutput("midrst_done_before", rr_done_count, 8'd1);
    rr_req_a_0 = 4'd9; rr_req_b_0 = 4'd4; rr_req_op_0 = 4'b0000; rr_req_valid_0 = 1'b1;
    @(negedge clk);
    checkOutput("midrst_accept", {7'd0, rr_req_ready_0}, 8'd1);
    @(posedge clk); #1;
    rr_req_valid_0 = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", {7'd0, rr_busy}, 8'd0);
    checkOutput("midrst_rsp_valid", {6'd0, rr_rsp_valid_1, rr_rsp_valid_0}, 8'd0);
    checkOutput("midrst_rsp_flags", {2'd0, rr_rsp_result, rr_rsp_carry, rr_rsp_zero}, 8'd0);
    checkOutput("midrst_done_count", rr_done_count, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checkOutput($sformatf("midrst_no_rsp_%0d", c), {6'd0, rr_rsp_valid_1, rr_rsp_valid_0}, 8'd0);
    end
    @(posedge clk); #1;

    // Fixed priority: requester 0 wins every grant while both valids are held.
    for (int g = 0; g < 4; g++) fp_q.push_back(mk(1'b0, 4'b1001, 1'b0, 1'b0, 1'b1));
    fp_req_a_0 = 4'b1001; fp_req_b_0 = 4'd0; fp_req_op_0 = 4'b1111; fp_req_valid_0 = 1'b1;
    fp_req_a_1 = 4'b0011; fp_req_b_1 = 4'd0; fp_req_op_1 = 4'b0100; fp_req_valid_1 = 1'b1;
    for (int g = 0; g < 4; g++) begin
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        checkOutput("fp_req_ready_1", {7'd0, fp_req_ready_1}, 8'd0);
        if (fp_req_ready_0) got = 1'b1;
      end
      if (!got) fail_now("fp_grant_timeout");
      @(posedge clk);
    end
    #1;
    fp_req_valid_0 = 1'b0;
    fp_req_valid_1 = 1'b0;
    wait_fp_idle();
    checkOutput("fp_done_count", fp_done_count, 8'd4);

    checkOutput("rr_queue_drained", 8'(rr_q.size()), 8'd0);
    checkOutput("fp_queue_drained", 8'(fp_q.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
